sprite_rom_arbiter: RTL and testbench

Shares one synchronous palette-index sprite ROM between several pixel-pipeline requesters: bird, pipe, score digits and coin. It replaces one-ROM-per-sprite with a single atlas read port. Arbitration is round-robin, one grant per clock. Each requester gets a one-cycle response strobe and a per-requester hold register, so the colour-mapping logic always sees a stable palette index.

---
 rtl/sprite_rom_arbiter_pkg.sv | 18 +
 rtl/sprite_rom_arbiter_if.sv | 33 +++
 rtl/sprite_rom_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/sprite_rom_arbiter.sv | 65 ++++++
 tb/tb_sprite_rom_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_pkg: shared types and constants for the sprite ROM arbiter.
//   req_id_e : requester index order (bird, pipe, score digits, coin)
//   SPRITE_ADDR_W / SPRITE_PAL_W : atlas address and palette index widths
//   pal_t    : one palette index
package sprite_pkg;
  localparam int SPRITE_NUM_REQ = 4;
  localparam int SPRITE_ADDR_W  = 19;
  localparam int SPRITE_PAL_W   = 4;

  typedef enum logic [1:0] {
    REQ_BIRD  = 2'd0,
    REQ_PIPE  = 2'd1,
    REQ_SCORE = 2'd2,
    REQ_COIN  = 2'd3
  } req_id_e;

  typedef logic [SPRITE_PAL_W-1:0] pal_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester / ROM bus of the sprite ROM arbiter.
//   req_valid/req_addr/req_ready : per-requester read handshake (addr packed, i at [i*ADDR_W +: ADDR_W])
//   mem_rd/mem_addr/mem_data     : single synchronous ROM port (data one cycle after mem_rd)
//   rsp_valid/rsp_data           : one-cycle response strobe plus data
//   palt_hold                    : last palette index returned to each requester
// Modports: slave = arbiter side, master = requesters + ROM side.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = SPRITE_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int PAL_W   = SPRITE_PAL_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [PAL_W-1:0]          mem_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [PAL_W-1:0]          rsp_data;
  logic [NUM_REQ*PAL_W-1:0]  palt_hold;

  modport slave (
    input  req_valid, req_addr, mem_data,
    output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, palt_hold
  );

  modport master (
    output req_valid, req_addr, mem_data,
    input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, palt_hold
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant among NUM_REQ requesters, one grant per clock.
//   Clk, Reset_n    : clock, async active-low reset (also gates the grant)
//   frame_start     : clears the rotation pointer (grant this cycle still uses old ptr)
//   req             : request vector
//   gnt / gnt_idx   : one-hot grant and its index (idx 0 when no grant)
// Build option SPRITE_ARB_FIXED_PRIO_EN: lowest index wins, pointer held at 0.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      // Scan starts at ptr and wraps, so the first hit is the next in rotation.
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
`endif
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    // No grants while reset is held.
    if (!Reset_n) begin
      found   = 1'b0;
      gnt_idx = '0;
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    ptr_d = ptr_q;
    if (found) ptr_d = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
    if (frame_start) ptr_d = '0;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among NUM_REQ pixel
// requesters with round-robin arbitration and one read per clock.
//   Clk, Reset_n : clock, async active-low reset
//   frame_start  : resynchronises the arbitration pointer
//   bus          : slave side of sprite_rom_arbiter_if (handshake, ROM port,
//                  response strobe, per-requester palette hold)
// Build option SPRITE_ARB_FIXED_PRIO_EN selects fixed priority inside rr_arbiter.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter  int NUM_REQ = SPRITE_NUM_REQ,
  parameter  int ADDR_W  = SPRITE_ADDR_W,
  parameter  int PAL_W   = SPRITE_PAL_W,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  sprite_rom_arbiter_if.slave  bus
);
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic [NUM_REQ-1:0]       tag_q, tag_d;
  logic                     inflight_q, inflight_d;
  logic [NUM_REQ*PAL_W-1:0] palt_q, palt_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .req         (bus.req_valid),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign bus.mem_rd    = |gnt;
  assign bus.mem_addr  = (|gnt) ? bus.req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;

  // The tag travels with the read so the returning data lands in the right
  // hold entry while the next read is already being issued.
  always_comb begin
    tag_d      = gnt;
    inflight_d = |gnt;
    palt_d     = palt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (tag_q[i]) palt_d[i*PAL_W +: PAL_W] = bus.mem_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_q      <= '0;
      inflight_q <= 1'b0;
      palt_q     <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      palt_q     <= palt_d;
    end
  end

  assign bus.rsp_valid = tag_q;
  assign bus.rsp_data  = inflight_q ? bus.mem_data : '0;
  assign bus.palt_hold = palt_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int PW = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_start = 1'b0;

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .PAL_W(PW)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .PAL_W(PW)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .bus         (bus)
  );

  always #5 Clk = ~Clk;

  // Behavioural ROM contents: a fixed hash of the address.
  function automatic logic [PW-1:0] rom(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]} ^ 4'h7;
  endfunction

  always @(posedge Clk) bus.mem_data <= rom(bus.mem_addr);

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  int            pend_g;
  logic [PW-1:0] pend_d;
  logic [PW-1:0] m_palt [N];
  int            last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    pend_g = -1;
    pend_d = '0;
    for (int i = 0; i < N; i++) m_palt[i] = '0;
  endtask

  // One clock of stimulus: drive at negedge, check after settle, then advance
  // the model across the following rising edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] addrs, input logic fs);
    int g;
    logic [N-1:0]    e_rdy, e_rsp;
    logic [AW-1:0]   e_addr;
    logic [N*PW-1:0] e_palt;
    @(negedge Clk);
    bus.req_valid = v;
    bus.req_addr  = addrs;
    frame_start   = fs;
    #1;
    g = -1;
    if (Reset_n) begin
      for (int k = 0; k < N; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        int idx = k;
`else
        int idx = (m_ptr + k) % N;
`endif
        if (g < 0 && v[idx]) g = idx;
      end
    end
    e_rdy  = (g >= 0) ? (N'(1) << g) : '0;
    e_addr = (g >= 0) ? addrs[g*AW +: AW] : '0;
    e_rsp  = (pend_g >= 0) ? (N'(1) << pend_g) : '0;
    for (int i = 0; i < N; i++) e_palt[i*PW +: PW] = m_palt[i];
    chk("req_ready", bus.req_ready, e_rdy);
    chk("mem_rd",    bus.mem_rd, (g >= 0));
    chk("mem_addr",  bus.mem_addr, e_addr);
    chk("rsp_valid", bus.rsp_valid, e_rsp);
    chk("rsp_data",  bus.rsp_data, (pend_g >= 0) ? pend_d : '0);
    chk("palt_hold", bus.palt_hold, e_palt);
    last_g = g;
    if (!Reset_n) begin
      model_reset();
    end else begin
      if (pend_g >= 0) m_palt[pend_g] = pend_d;
      pend_g = g;
      pend_d = (g >= 0) ? rom(e_addr) : '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      if (g >= 0) m_ptr = (g + 1) % N;
      if (fs) m_ptr = 0;
`endif
    end
  endtask

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    model_reset();
    @(posedge Clk); #2;
    Reset_n = 1'b1;
  endtask

  logic [N*AW-1:0] addrs;

  initial begin
    model_reset();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    last_g = -1;

    // Reset state, with requests pending: nothing may be granted.
    cycle(4'b1111, rand_addrs(), 1'b0);
    chk("rst_gnt", last_g, -1);
    @(posedge Clk); #2;
    Reset_n = 1'b1;

    // Single request from the pipe requester.
    addrs = rand_addrs();
    addrs[1*AW +: AW] = 19'h00123;
    cycle(4'b0010, addrs, 1'b0);
    chk("single_gnt", last_g, 1);
    chk("single_addr", bus.mem_addr, 19'h00123);
    cycle(4'b0000, addrs, 1'b0);
    chk("single_rsp_v", bus.rsp_valid, 4'b0010);
    chk("single_rsp_d", bus.rsp_data, 4'h7);
    cycle(4'b0000, addrs, 1'b0);
    chk("single_palt1", bus.palt_hold[1*PW +: PW], 4'h7);

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    // All valid from reset: strict rotation, a read every cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, rand_addrs(), 1'b0);
      chk("rot_gnt", last_g, i % N);
      chk("rot_rd", bus.mem_rd, 1'b1);
    end

    // frame_start with ptr=2: this cycle still grants 2, next grants 0.
    cycle(4'b1111, rand_addrs(), 1'b0);
    cycle(4'b1111, rand_addrs(), 1'b0);
    cycle(4'b1111, rand_addrs(), 1'b1);
    chk("fs_same", last_g, 2);
    cycle(4'b1111, rand_addrs(), 1'b0);
    chk("fs_next", last_g, 0);

    // Idle cycles keep ptr (=1) and the hold registers.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, rand_addrs(), 1'b0);
      chk("idle_addr", bus.mem_addr, 19'h0);
    end
    cycle(4'b1111, rand_addrs(), 1'b0);
    chk("idle_ptr", last_g, 1);
`else
    // Fixed priority: bird always beats coin.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1001, rand_addrs(), 1'b0);
      chk("fixed_gnt", last_g, 0);
    end
    cycle(4'b1111, rand_addrs(), 1'b1);
    chk("fixed_fs", last_g, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(N'($urandom), rand_addrs(), ($urandom_range(0, 7) == 0));

    // Reset in the middle of a read to the score requester.
    do_reset();
    addrs = rand_addrs();
    addrs[2*AW +: AW] = 19'h00400;
    cycle(4'b0100, addrs, 1'b0);
    chk("rmid_gnt", last_g, 2);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rmid_rsp_in_rst", bus.rsp_valid, 4'b0000);
    cycle(4'b0100, addrs, 1'b0);
    @(posedge Clk); #2;
    Reset_n = 1'b1;
    cycle(4'b0000, addrs, 1'b0);
    chk("rmid_rsp_after", bus.rsp_valid, 4'b0000);
    cycle(4'b0000, addrs, 1'b0);
    chk("rmid_palt2", bus.palt_hold[2*PW +: PW], 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
